// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder for an asynchronous master: oversampled pins, 16-bit R/W frames, 8x8 register file.
// Host read port returns reg[host_addr] one clk later; SPI writes commit on the 16th SCLK rise.
module spi_slave_regfile #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [2:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       wr_pulse,
  output logic [2:0] wr_addr,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CS} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] cmd_sr_q, cmd_sr_d;
  logic [6:0] data_sr_q, data_sr_d;
  logic [2:0] addr_q, addr_d;
  logic       rd_q, rd_d;
  logic [7:0] out_sr_q, out_sr_d;
  logic       miso_q, miso_d;
  logic       wr_pulse_q, wr_pulse_d;
  logic [2:0] wr_addr_q, wr_addr_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] host_rdata_q;
  logic [7:0] regs_q [8];
  logic       reg_we;
  logic [7:0] reg_wdata;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    cmd_sr_d     = cmd_sr_q;
    data_sr_d    = data_sr_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    out_sr_d     = out_sr_q;
    miso_d       = miso_q;
    wr_pulse_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    reg_we       = 1'b0;
    reg_wdata    = {data_sr_q, mosi_s};
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
        end
      end
      CMD: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          cmd_sr_d  = {cmd_sr_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          // Eighth command bit arrives now: the byte is {cmd_sr_q, mosi_s}.
          if (bit_cnt_q == 4'd7) begin
            addr_d  = {cmd_sr_q[1:0], mosi_s};
            rd_d    = cmd_sr_q[6];
            state_d = DATA;
            if (cmd_sr_q[6]) out_sr_d = regs_q[{cmd_sr_q[1:0], mosi_s}];
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          data_sr_d = {data_sr_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            miso_d  = 1'b0;
            state_d = WAIT_CS;
            if (!rd_q) begin
              reg_we     = 1'b1;
              wr_pulse_d = 1'b1;
              wr_addr_d  = addr_q;
            end
          end
        end else if (sclk_fall && rd_q) begin
          miso_d   = out_sr_q[7];
          out_sr_d = {out_sr_q[6:0], 1'b0};
        end
      end
      WAIT_CS: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizers reset to the idle bus level so release never fakes an edge.
      sclk_sync_q  <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      cmd_sr_q     <= '0;
      data_sr_q    <= '0;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      out_sr_q     <= '0;
      miso_q       <= 1'b0;
      wr_pulse_q   <= 1'b0;
      wr_addr_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      host_rdata_q <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q  <= sclk_s;
      cs_prev_q    <= cs_s;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      cmd_sr_q     <= cmd_sr_d;
      data_sr_q    <= data_sr_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      out_sr_q     <= out_sr_d;
      miso_q       <= miso_d;
      wr_pulse_q   <= wr_pulse_d;
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      host_rdata_q <= regs_q[host_addr];
      if (reg_we) regs_q[addr_q] <= reg_wdata;
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = ~cs_s;
  assign host_rdata = host_rdata_q;
  assign wr_pulse   = wr_pulse_q;
  assign wr_addr    = wr_addr_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/spi_slave_regfile.md
# spi_slave_regfile

SPI responder for an external, asynchronous SPI master. It oversamples SCLK, CS_N and MOSI on the system clock, decodes 16-bit mode-0 frames, and serves reads and writes to an internal 8×8-bit register file. It is the far end of the SPI link the team's master drives. Unlike the existing slave, it does not share the system clock with the master. A host-side read port exposes register contents to the rest of the design.

## Interface
- SYNC_STAGES, 2, synchronizer depth for sclk/cs_n/mosi (≥2)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sclk  in  1  SPI clock from external master, asynchronous to clk, idle low (CPOL=0)
- cs_n  in  1  chip select, active low, asynchronous
- mosi  in  1  master-out data, asynchronous
- miso  out  1  slave-out data
- miso_oe  out  1  1 while the frame is active (cs_n synchronized low)
- host_addr  in  3  host read address
- host_rdata  out  8  registered host read data
- wr_pulse  out  1  one-cycle pulse when an SPI write commits
- wr_addr  out  3  address of the committed write, valid with wr_pulse
- frame_done  out  1  one-cycle pulse when a complete 16-bit frame ends
- frame_err  out  1  one-cycle pulse when cs_n rises before 16 bits

## Operation
- Frame format: MSB first, 16 bits.
  - bit15: R/W̄ (1 = read).
  - bits14:8: address. Only bits10:8 are used; bits14:11 are ignored.
  - bits7:0: write data, or don't-care on a read.
- Mode 0 timing: MOSI is sampled on synchronized SCLK rising edges. MISO changes on synchronized SCLK falling edges.
- Synchronizers and edge detect: SYNC_STAGES flops on each async input. Edges are detected by comparing the last synchronized SCLK sample with the previous one.
- FSM states: IDLE, CMD, DATA, WAIT_CS.
  - IDLE → CMD on synced cs_n falling. Bit counter cleared; miso = 0.
  - CMD: counts 8 rising edges into the command shift register. On the 8th rising edge, latch address and R/W̄. If read, load the output shifter with reg[addr] in the same cycle. → DATA.
  - DATA: counts 8 rising edges. Read: reg bit7 is driven on the 8th falling edge, then bits 6..0 on following falling edges. Write: on the 16th rising edge, reg[addr] ← data byte; wr_pulse and wr_addr are asserted the next cycle. → WAIT_CS.
  - WAIT_CS: further SCLK edges are ignored and miso holds 0. On synced cs_n rising, pulse frame_done → IDLE.
  - In CMD or DATA, synced cs_n rising: pulse frame_err, perform no write, → IDLE.
- miso is 0 in IDLE, in CMD, during write frames, and in WAIT_CS.
- Register file: 8×8 bits, reset to 0x00.
- Host read port: host_rdata ← reg[host_addr] on every clk.
  - If an SPI write and a host read hit the same address in the same cycle, the host sees the old value (read-before-write).
- Reset: returns the FSM to IDLE whenever rst is high, including mid-frame. Clears the registers, counters and shifters. The aborted frame produces no wr_pulse and no frame_err.
- Outputs after reset: miso=0, miso_oe=0, host_rdata=0x00, wr_pulse=0, wr_addr=0, frame_done=0, frame_err=0.

## Timing
- Input detection latency: SYNC_STAGES+1 clk cycles from a pin transition to the internal edge event. This is 3 cycles at the default depth.
- SCLK constraints: high and low phases must each be ≥ SYNC_STAGES+2 clk cycles. cs_n setup before the first SCLK rise must be ≥ SYNC_STAGES+2 clk cycles. Behaviour outside these limits is unspecified.
- MISO update: 1 clk after the internal falling-edge event.
- wr_pulse: 1 clk after the 16th internal rising-edge event; the register is updated in that same edge cycle.
- frame_done / frame_err: 1 clk after the internal cs_n rising event.
- host_rdata: 1 clk latency from host_addr.
- Back-to-back frames: cs_n may fall again once frame_done or frame_err has pulsed; no additional idle cycles are required.

## Test plan
- Write frame 0x0355 (write, addr 3, data 0x55) with SCLK at clk/8 → wr_pulse once with wr_addr=3; host_addr=3 yields host_rdata=0x55; frame_done pulses once after cs_n rises.
- Write 0x0355, then read frame 0x8300 → MISO bits 7..0 read 0x55 MSB first; MISO=0 during bits 15..8; no wr_pulse on the read frame.
- Abort: cs_n rises after 10 bits of write 0x07AA → frame_err pulses, frame_done stays 0, reg[7] stays 0x00, no wr_pulse.
- Extra clocks: write 0x0111 followed by 4 extra SCLK cycles before cs_n rises → reg[1]=0x11, exactly one wr_pulse, MISO=0 during the extra clocks.
- Reset mid-frame: assert rst during bit 12 of write 0x0466 → reg[4]=0x00, all outputs at reset values; the next full write 0x0466 succeeds.
- Address aliasing and collision: write 0x7A0F (bits14:11 set, addr 2) → reg[2]=0x0F; holding host_addr=2 during the commit cycle returns the old value, then 0x0F on the next cycle.
